// File: rtl/geofence_feeder_pkg.sv
// rtl/geofence_feeder_pkg.sv - shared types and constants for the geofence feeder
package geofence_feeder_pkg;

  localparam int COORD_W         = 10;
  localparam int POINTS          = 7;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  // A requested count of 0 still runs one case; oversized requests saturate.
  function automatic logic [2:0] clamp_count(input logic [2:0] n, input int max_n);
    if (n == 3'd0) return 3'd1;
    if (int'(n) > max_n) return 3'(max_n);
    return n;
  endfunction

endpackage

// File: rtl/geofence_feeder_if.sv
// rtl/geofence_feeder_if.sv - point/result handshake between feeder and geofence engine
interface geofence_feeder_if;
  import geofence_feeder_pkg::*;

  logic [COORD_W-1:0] X;
  logic [COORD_W-1:0] Y;
  logic               pt_valid;
  logic               valid;
  logic               is_inside;

  modport master (output X, Y, pt_valid, input valid, is_inside);
  modport slave  (input X, Y, pt_valid, output valid, is_inside);

endinterface

// File: rtl/geofence_case_ram.sv
// rtl/geofence_case_ram.sv - case point storage, synchronous write, asynchronous read
module geofence_case_ram #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int W     = 20
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  // Not reset: case contents survive a run abort.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - replays stored cases to a geofence engine and collects verdicts
module geofence_feeder
  import geofence_feeder_pkg::*;
#(
  parameter int NUM_CASES = 4,
  parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_case,
  input  logic [2:0]           cfg_pt,
  input  logic [COORD_W-1:0]   cfg_x,
  input  logic [COORD_W-1:0]   cfg_y,
  input  logic [2:0]           num_cases,
  input  logic                 start,
  geofence_feeder_if.master    eng,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CASES-1:0] results,
  output logic                 timeout
);

  localparam int DEPTH = NUM_CASES * POINTS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CIW   = (NUM_CASES > 1) ? $clog2(NUM_CASES) : 1;

  state_t               r_state, w_next;
  logic [CIW-1:0]       r_case_idx;
  logic [2:0]           r_pt;
  logic [7:0]           r_wait;
  logic [2:0]           r_count;
  logic [NUM_CASES-1:0] r_results;
  logic                 r_timeout;

  logic                 w_we;
  logic [AW-1:0]        w_waddr, w_raddr;
  logic [2*COORD_W-1:0] w_rdata;
  logic                 w_last_case, w_expire;
  logic [COORD_W-1:0]   w_x, w_y;
  logic                 w_pt_valid, w_busy, w_done;

  assign w_we    = cfg_we && (cfg_pt != 3'd7) && (int'(cfg_case) < NUM_CASES);
  assign w_waddr = AW'(int'(cfg_case) * POINTS + int'(cfg_pt));
  assign w_raddr = AW'(int'(r_case_idx) * POINTS + int'(r_pt));

  geofence_case_ram #(.DEPTH(DEPTH), .AW(AW), .W(2*COORD_W)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({cfg_x, cfg_y}),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign w_last_case = (int'(r_case_idx) == int'(r_count) - 1);
  // Expiry lands on the TIMEOUT-th WAIT cycle; a valid in that same cycle still wins.
  assign w_expire    = (int'(r_wait) + 1 >= TIMEOUT);

  always_comb begin
    w_next     = r_state;
    w_x        = '0;
    w_y        = '0;
    w_pt_valid = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_SEND;
      S_SEND: begin
        w_busy     = 1'b1;
        w_pt_valid = 1'b1;
        w_x        = w_rdata[2*COORD_W-1:COORD_W];
        w_y        = w_rdata[COORD_W-1:0];
        if (r_pt == 3'd6) w_next = S_WAIT;
      end
      S_WAIT: begin
        w_busy = 1'b1;
        if (eng.valid || w_expire) w_next = S_CAPT;
      end
      S_CAPT: begin
        w_busy = 1'b1;
        w_next = w_last_case ? S_DONE : S_SEND;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_case_idx <= '0;
      r_pt       <= '0;
      r_wait     <= '0;
      r_count    <= 3'd1;
      r_results  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (start) begin
          r_count    <= clamp_count(num_cases, NUM_CASES);
          r_case_idx <= '0;
          r_pt       <= '0;
          r_results  <= '0;
          r_timeout  <= 1'b0;
        end
        S_SEND: begin
          r_pt   <= (r_pt == 3'd6) ? 3'd0 : r_pt + 3'd1;
          r_wait <= '0;
        end
        S_WAIT: begin
          r_wait <= r_wait + 8'd1;
          if (eng.valid) begin
            r_results[r_case_idx] <= eng.is_inside;
          end else if (w_expire) begin
            r_results[r_case_idx] <= 1'b0;
            r_timeout             <= 1'b1;
          end
        end
        S_CAPT: if (!w_last_case) r_case_idx <= r_case_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign eng.X        = w_x;
  assign eng.Y        = w_y;
  assign eng.pt_valid = w_pt_valid;
  assign busy         = w_busy;
  assign done         = w_done;
  assign results      = r_results;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_geofence_feeder.sv
// tb/tb_geofence_feeder.sv - scoreboard bench for geofence_feeder
module tb_geofence_feeder;

  localparam int NC  = 4;
  localparam int TMO = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_case = '0;
  logic [2:0]    cfg_pt = '0;
  logic [9:0]    cfg_x = '0, cfg_y = '0;
  logic [2:0]    num_cases = 3'd1;
  logic          start = 1'b0;
  logic          busy, done, timeout;
  logic [NC-1:0] results;

  geofence_feeder_if eng();

  geofence_feeder #(.NUM_CASES(NC), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_case  (cfg_case),
    .cfg_pt    (cfg_pt),
    .cfg_x     (cfg_x),
    .cfg_y     (cfg_y),
    .num_cases (num_cases),
    .start     (start),
    .eng       (eng),
    .busy      (busy),
    .done      (done),
    .results   (results),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [9:0]  mx [NC][7];
  logic [9:0]  my [NC][7];
  logic [19:0] exp_q [$];
  logic [NC-1:0] exp_res;
  logic        exp_to;

  task automatic write_pt(input int c, input int k, input logic [9:0] x, input logic [9:0] y);
    cfg_we = 1'b1; cfg_case = 2'(c); cfg_pt = 3'(k); cfg_x = x; cfg_y = y;
    if (k != 7) begin mx[c][k] = x; my[c][k] = y; end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_cases();
    int hx[7] = '{200, 100, 150, 250, 300, 250, 150};
    int hy[7] = '{200, 200, 100, 100, 200, 300, 300};
    for (int k = 0; k < 7; k++) write_pt(0, k, 10'(hx[k]), 10'(hy[k]));
    for (int c = 1; c < NC; c++)
      for (int k = 0; k < 7; k++) write_pt(c, k, 10'(c*100 + k*10 + 1), 10'(c*50 + k*7 + 3));
    write_pt(1, 7, 10'h3ff, 10'h3ff);
  endtask

  task automatic start_run(input logic [2:0] n);
    int eff;
    eff = (n == 0) ? 1 : (int'(n) > NC) ? NC : int'(n);
    for (int c = 0; c < eff; c++)
      for (int k = 0; k < 7; k++) exp_q.push_back({mx[c][k], my[c][k]});
    exp_res = '0; exp_to = 1'b0;
    num_cases = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered on the cycle carrying point 0; leaves on the cycle after CAPT.
  task automatic do_case(input int idx, input int vcycle, input bit ins, input bit poke);
    logic [19:0] e;
    for (int k = 0; k < 7; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
      checks++;
      if (eng.pt_valid !== 1'b1 || {eng.X, eng.Y} !== e) begin
        errors++;
        $display("FAIL point c%0d k%0d: got v=%b xy=%h want v=1 xy=%h", idx, k, eng.pt_valid, {eng.X, eng.Y}, e);
      end
      start = (poke && k == 2);
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (eng.pt_valid !== 1'b0 || eng.X !== 10'd0 || eng.Y !== 10'd0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry c%0d: got v=%b x=%0d y=%0d busy=%b done=%b want 0 0 0 1 0", idx, eng.pt_valid, eng.X, eng.Y, busy, done);
    end
    if (vcycle > 0) begin
      repeat (vcycle - 1) @(negedge clk);
      eng.valid = 1'b1; eng.is_inside = ins;
      @(negedge clk);
      eng.valid = 1'b0; eng.is_inside = 1'b0;
      exp_res[idx] = ins;
    end else begin
      repeat (TMO - 1) @(negedge clk);
      checks++;
      if (timeout !== exp_to || busy !== 1'b1 || eng.pt_valid !== 1'b0) begin
        errors++;
        $display("FAIL pre_expiry c%0d: got to=%b busy=%b v=%b want to=%b busy=1 v=0", idx, timeout, busy, eng.pt_valid, exp_to);
      end
      @(negedge clk);
      exp_res[idx] = 1'b0; exp_to = 1'b1;
    end
    checks++;
    if (results !== exp_res || timeout !== exp_to || busy !== 1'b1 || eng.pt_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL capt c%0d: got res=%b to=%b busy=%b v=%b done=%b want res=%b to=%b 1 0 0", idx, results, timeout, busy, eng.pt_valid, done, exp_res, exp_to);
    end
    @(negedge clk);
  endtask

  task automatic expect_done();
    checks++;
    if (done !== 1'b1 || results !== exp_res || timeout !== exp_to || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL done: got done=%b res=%b to=%b busy=%b left=%0d want 1 %b %b 0 0", done, results, timeout, busy, exp_q.size(), exp_res, exp_to);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || eng.pt_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b v=%b want 0 0 0", done, busy, eng.pt_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    eng.valid = 1'b0; eng.is_inside = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (eng.X !== 0 || eng.Y !== 0 || eng.pt_valid !== 0 || busy !== 0 || done !== 0 || results !== 0 || timeout !== 0) begin
      errors++;
      $display("FAIL reset: got x=%0d y=%0d v=%b busy=%b done=%b res=%b to=%b want all 0", eng.X, eng.Y, eng.pt_valid, busy, done, results, timeout);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    start_run(3'd1);
    do_case(0, 3, 1'b1, 1'b0);
    expect_done();
    repeat (4) @(negedge clk);
    checks++;
    if (results !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL hold: got res=%b to=%b want 0001 0", results, timeout);
    end
  endtask

  task automatic test_multi();
    start_run(3'd4);
    do_case(0, 1, 1'b1, 1'b0);
    do_case(1, 2, 1'b0, 1'b1);
    do_case(2, 5, 1'b1, 1'b0);
    do_case(3, 1, 1'b0, 1'b0);
    expect_done();
  endtask

  task automatic test_timeout();
    start_run(3'd2);
    do_case(0, 0, 1'b0, 1'b0);
    do_case(1, 1, 1'b1, 1'b0);
    expect_done();
  endtask

  task automatic test_simultaneous();
    start_run(3'd1);
    do_case(0, TMO, 1'b1, 1'b1);
    expect_done();
  endtask

  task automatic test_reset_mid();
    logic [19:0] e;
    start_run(3'd1);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (eng.pt_valid !== 1'b1 || {eng.X, eng.Y} !== e) begin
        errors++;
        $display("FAIL rst_point k%0d: got v=%b xy=%h want v=1 xy=%h", k, eng.pt_valid, {eng.X, eng.Y}, e);
      end
      if (k < 3) @(negedge clk);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (eng.X !== 0 || eng.Y !== 0 || eng.pt_valid !== 0 || busy !== 0 || done !== 0 || results !== 0 || timeout !== 0) begin
      errors++;
      $display("FAIL mid_reset: got x=%0d y=%0d v=%b busy=%b done=%b res=%b to=%b want all 0", eng.X, eng.Y, eng.pt_valid, busy, done, results, timeout);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset: got done=%b busy=%b want 0 0", done, busy);
      end
    end
    start_run(3'd1);
    do_case(0, 2, 1'b1, 1'b0);
    expect_done();
  endtask

  task automatic test_count_clamp();
    start_run(3'd0);
    do_case(0, 1, 1'b1, 1'b0);
    expect_done();
    start_run(3'd7);
    do_case(0, 1, 1'b0, 1'b0);
    do_case(1, 1, 1'b1, 1'b0);
    do_case(2, 1, 1'b1, 1'b0);
    do_case(3, 1, 1'b1, 1'b0);
    expect_done();
  endtask

  initial begin
    test_reset();
    load_cases();
    test_single();
    test_multi();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_count_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/geofence_feeder.md
GEOFENCE_FEEDER -- requirements
Module: geofence_feeder

Interface
REQ-001 Parameter NUM_CASES, default 4: number of case slots in the case buffer.
REQ-002 Parameter TIMEOUT, default 255: maximum number of WAIT cycles without valid before a case aborts.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cfg_we  input  1  case-buffer write strobe.
REQ-006 cfg_case  input  2  case slot index, 0..NUM_CASES-1.
REQ-007 cfg_pt  input  3  point index: 0 = target, 1..6 = fence vertices; 7 is ignored.
REQ-008 cfg_x / cfg_y  input  10 each  point coordinates.
REQ-009 num_cases  input  3  number of cases to run, 1..NUM_CASES; sampled on start.
REQ-010 start  input  1  single-cycle run request, honoured only in IDLE.
REQ-011 X / Y  output  10 each  point coordinates driven to the geofence engine.
REQ-012 pt_valid  output  1  high while X/Y carry a point.
REQ-013 valid  input  1  engine result strobe.
REQ-014 is_inside  input  1  engine result, qualified by valid.
REQ-015 busy  output  1  high in SEND, WAIT or CAPT.
REQ-016 done  output  1  one-cycle pulse at the end of a run.
REQ-017 results  output  NUM_CASES  bit k holds the captured is_inside of case k.
REQ-018 timeout  output  1  sticky flag: at least one case in the run timed out.

Function
REQ-019 Case buffer: NUM_CASES x 7 entries of {x,y}, written synchronously on cfg_we; writes with cfg_pt=7 or cfg_case>=NUM_CASES are dropped.
REQ-020 Writes are accepted in every state; a write to the case currently being sent takes effect from the next point read.
REQ-021 FSM states: IDLE, SEND, WAIT, CAPT, DONE.
REQ-022 IDLE -> SEND on start: latch num_cases, clamping 0 to 1 and values >NUM_CASES to NUM_CASES; clear case_idx, results and timeout.
REQ-023 SEND lasts exactly 7 cycles.
REQ-024 In SEND cycle k (k=0..6), X/Y = buffer[case_idx][k] and pt_valid = 1; target first, then vertices 1..6 in buffer order.
REQ-025 SEND -> WAIT after point 6; in WAIT, X/Y are 0 and pt_valid is 0.
REQ-026 WAIT -> CAPT on valid=1; results[case_idx] <= is_inside in that same cycle.
REQ-027 WAIT wait counter: 8 bits, cleared on WAIT entry, increments each WAIT cycle.
REQ-028 When the wait counter reaches TIMEOUT with no valid: results[case_idx] <= 0, timeout <= 1, go to CAPT.
REQ-029 valid and timeout expiry in the same cycle: the valid path wins and the result is captured.
REQ-030 CAPT (1 cycle): if case_idx == latched count-1 go to DONE; otherwise increment case_idx and go to SEND.
REQ-031 Next-case latency: first point of case n+1 appears 2 cycles after the valid of case n.
REQ-032 DONE (1 cycle): done=1, then go to IDLE; results and timeout hold until the next start.
REQ-033 valid outside WAIT is ignored.
REQ-034 start outside IDLE is ignored.

Reset
REQ-035 On reset: state IDLE; X=0, Y=0, pt_valid=0, busy=0, done=0, results=0, timeout=0; case_idx and wait counter cleared.
REQ-036 The case buffer is not reset; reset asserted mid-run aborts the run immediately with no done pulse.

Structure
REQ-037 A shared package holds the state enum, coordinate width (10), points per case (7) and the default TIMEOUT.
REQ-038 One sub-module, geofence_case_ram (NUM_CASES*7 x 20-bit, synchronous write, asynchronous read); the FSM and counters live in the top level.

Verification
REQ-039 Single-case send: load case 0 as target (200,200) and hexagon (100,200),(150,100),(250,100),(300,200),(250,300),(150,300); num_cases=1, start -> 7 consecutive pt_valid cycles in exactly that order; model valid=1, is_inside=1 on the 3rd WAIT cycle -> results[0]=1, done pulses 2 cycles after valid.
REQ-040 Multi-case run: num_cases=4 with model results 1,0,1,0 -> results=4'b0101, single done pulse, second case's first point 2 cycles after the first valid.
REQ-041 Timeout: model never asserts valid -> after 255 WAIT cycles timeout=1, results[0]=0, and the run continues with the next case.
REQ-042 Simultaneous events: valid=1 on the same cycle the counter reaches TIMEOUT -> result captured, timeout stays 0; start during SEND is ignored.
REQ-043 Reset in SEND cycle 3 -> all outputs 0 next edge, no done pulse; a new start replays case 0 from its target point.
REQ-044 num_cases=0 -> exactly one case runs; num_cases=7 -> 4 cases run.
